// File: rtl/fifo_axis_egress_if.sv
// Interface for fifo_axis_egress: FIFO read port (rd_en/empty/data) and the AXI-Stream master side.
// The master modport is the egress block; the slave modport is the FIFO plus the stream sink.
interface fifo_axis_egress_if;
  localparam int unsigned DATA_W = 32;

  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_en;
  logic              m_tvalid;
  logic              m_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    input  m_tready,
    output fifo_rd_en,
    output m_tvalid,
    output m_tdata,
    output m_tlast
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    output m_tready,
    input  fifo_rd_en,
    input  m_tvalid,
    input  m_tdata,
    input  m_tlast
  );
endinterface

// File: rtl/fifo_axis_egress.sv
// Pops the user FIFO (1-cycle read latency) into a 2-entry skid buffer and drives an AXI-Stream master,
// inserting tlast every PKT_LEN beats. Optional beat/packet counters under FIFO_EGRESS_STATS_EN.
module fifo_axis_egress #(
  parameter int unsigned PKT_LEN = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  fifo_axis_egress_if.master bus,
  output logic               busy
`ifdef FIFO_EGRESS_STATS_EN
  ,
  output logic [31:0]        beat_total,
  output logic [15:0]        pkt_total
`endif
);

  localparam int unsigned       DATA_W    = 32;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(PKT_LEN - 1);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] spare_q, spare_d;
  logic [1:0]        occ_q, occ_d;
  logic              pending_q, pending_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;

  logic              hs;
  logic [2:0]        occ_sum;
  logic [1:0]        occ_after_hs;
  logic              rd_en;

  // Words held after this cycle's handshake and capture; pop only while that leaves a free slot.
  assign hs           = valid_q & bus.m_tready;
  assign occ_sum      = 3'(occ_q) + 3'(pending_q) - 3'(hs);
  assign occ_after_hs = occ_q - 2'(hs);
  assign rd_en        = ~reset & en & ~bus.fifo_empty & (occ_sum < 3'd2);

  always_comb begin
    head_d    = head_q;
    spare_d   = spare_q;
    occ_d     = occ_sum[1:0];
    pending_d = rd_en;
    cnt_d     = cnt_q;

    if (hs && (occ_q == 2'd2)) begin
      head_d = spare_q;
    end

    // The word popped last cycle lands in head if head frees up, otherwise behind it.
    if (pending_q) begin
      if (occ_after_hs == 2'd0) begin
        head_d = bus.fifo_rd_data;
      end else begin
        spare_d = bus.fifo_rd_data;
      end
    end

    if (hs) begin
      cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_W'(1);
    end

    valid_d = (occ_d != 2'd0);
    last_d  = valid_d & (cnt_d == LAST_BEAT);
    busy_d  = valid_d | pending_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      spare_q   <= '0;
      occ_q     <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      head_q    <= head_d;
      spare_q   <= spare_d;
      occ_q     <= occ_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_tvalid   = valid_q;
  assign bus.m_tdata    = head_q;
  assign bus.m_tlast    = last_q;
  assign busy           = busy_q;

`ifdef FIFO_EGRESS_STATS_EN
  logic [31:0] beat_q, beat_d;
  logic [15:0] pkt_q, pkt_d;

  always_comb begin
    beat_d = beat_q + 32'(hs);
    pkt_d  = pkt_q + 16'(hs & last_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q <= '0;
      pkt_q  <= '0;
    end else begin
      beat_q <= beat_d;
      pkt_q  <= pkt_d;
    end
  end

  assign beat_total = beat_q;
  assign pkt_total  = pkt_q;
`endif

  // A full buffer can never also have a word arriving without one leaving.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !((occ_q == 2'd2) && pending_q && !hs));

  a_stall_stable: assert property (@(posedge clk) disable iff (reset)
    (valid_q && !bus.m_tready) |=> ($stable(head_q) && $stable(last_q) && valid_q));

endmodule

// File: doc/fifo_axis_egress.md
Name: fifo_axis_egress

Overview:
Downstream consumer of the 5-entry 32-bit user FIFO. It pops words using that FIFO's rd_en/empty interface, which has 1-cycle registered read latency, and presents them as an AXI-Stream master toward the user-project DMA/tap path.
- Sustains one beat per cycle.
- Absorbs downstream backpressure in a 2-entry skid buffer.
- Inserts tlast every PKT_LEN beats.

Parameters:
PKT_LEN, 64, beats per packet; tlast asserted on beat PKT_LEN-1; legal range 1..65535
CNT_W, 16, width of the internal beat counter; must satisfy 2^CNT_W >= PKT_LEN

Ports:
clk  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
en  input  1  allow new FIFO pops; level-sensitive
fifo_empty  input  1  FIFO empty flag
fifo_rd_data  input  32  FIFO read data; valid the cycle after a pop
fifo_rd_en  output  1  FIFO pop request
m_tvalid  output  1  AXI-Stream valid
m_tready  input  1  AXI-Stream ready
m_tdata  output  32  AXI-Stream data
m_tlast  output  1  end of packet
busy  output  1  high while occ != 0 or pending == 1

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on the reset port.
- Reset values, on the clk edge with reset=1:
  - fifo_rd_en=0, m_tvalid=0, m_tdata=0, m_tlast=0, busy=0.
  - occ=0, pending=0, beat counter=0.
  - Reset mid-operation discards buffered and in-flight words; the FIFO is reset by the same signal.
- Internal state:
  - Skid buffer of 2 entries: head (drives m_tdata) and spare. occ in 0..2.
  - pending flag = fifo_rd_en was high last cycle.
  - hs = m_tvalid & m_tready.
- Pop rule (combinational):
  - fifo_rd_en = en & ~fifo_empty & ((occ + pending - hs) < 2).
  - This guarantees no overflow and gives full throughput: steady state occ=1, pending=1, hs=1.
- Capture:
  - When pending=1, fifo_rd_data is written into the buffer in the same cycle.
  - Target is head if head is empty after this cycle's hs; otherwise spare.
  - On hs with occ=2, spare moves to head.
- Ordering: strict FIFO order; no word dropped or duplicated.
- Latency: pop at cycle N puts data at m_tdata with m_tvalid=1 at cycle N+2 (one cycle of FIFO latency plus one buffer register). This holds when the buffer is empty.
- m_tvalid = (occ != 0), registered.
- AXI-Stream stability: while m_tvalid=1 and m_tready=0, m_tdata and m_tlast are held constant.
- tlast and the beat counter:
  - m_tlast = (beat counter == PKT_LEN-1), evaluated for the head word.
  - The counter increments on hs and wraps to 0 after PKT_LEN-1.
  - With PKT_LEN=1, every beat has tlast=1.
- en deassertion:
  - No new pops.
  - A pending word is still captured.
  - Buffered words still drain.
  - The beat counter is not cleared.
- FIFO empty: no pop. m_tvalid falls after the last buffered word completes its handshake (no bubble insertion otherwise).
- Simultaneous capture and handshake in one cycle:
  - occ_next = occ + pending - hs.
  - occ_next is never > 2 and never < 0.
- busy = (occ != 0) | pending.

Optional Feature:
Macro FIFO_EGRESS_STATS_EN.
- Defined:
  - Adds outputs beat_total[31:0] and pkt_total[15:0].
  - beat_total increments on every hs.
  - pkt_total increments on hs with m_tlast=1.
  - Both wrap modulo 2^width and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset with FIFO preloaded and m_tready=1.
   -> All outputs 0 during reset.
   -> First pop one cycle after reset deasserts.
   -> m_tvalid at pop+2.
2. FIFO holds 5 words 0xA0..0xA4, en=1, m_tready=1 constant.
   -> 5 consecutive beats 0xA0..0xA4 with no bubbles.
   -> m_tvalid drops the cycle after the 0xA4 handshake.
   -> busy=0 afterwards.
3. Stream of 10 words with m_tready held 0 for 6 cycles mid-stream.
   -> fifo_rd_en stops once occ+pending reaches 2.
   -> m_tdata is stable while stalled.
   -> Order is preserved after release; no loss or duplication.
4. PKT_LEN=4, 12 words.
   -> m_tlast high on beats 3, 7 and 11 only.
   -> With FIFO_EGRESS_STATS_EN: beat_total=12, pkt_total=3.
5. en cleared the same cycle as a pop.
   -> That word still appears at m_tdata.
   -> No further fifo_rd_en while en=0, even with fifo_empty=0.
6. Reset asserted with occ=2 and pending=1.
   -> Next cycle m_tvalid=0, busy=0, beat counter 0.
   -> First post-reset beat has m_tlast=0 (PKT_LEN>1).
